// File: rtl/cmd_programmer.sv
// Keypad/encoder command entry with a register-file commit handshake.
// Optional read-back verify: define CMD_PROG_VERIFY_EN.
module cmd_programmer #(
  parameter int DIGITS      = 8,
  parameter int ADDR_W      = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic                        cur_sel,
  input  logic                        wr_en,
  input  logic                        key_valid,
  input  logic [3:0]                  key,
  input  logic                        enc_add,
  input  logic                        enc_sub,
  input  logic                        btn,
  input  logic                        clear,
  input  logic [$clog2(DIGITS)-1:0]   disp_sel,
  input  logic [DIGITS*4-1:0]         rf_rdata,
  input  logic                        rf_ack,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_addr,
  output logic [DIGITS*4-1:0]         rf_wdata,
  output logic                        busy,
  output logic                        err,
  output logic [3:0]                  disp_val,
  output logic                        disp_dot
);

  localparam int CW = $clog2(DIGITS);
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    VERIFY,
    ADV
  } state_t;

  state_t              state;
  logic [DIGITS*4-1:0] data_q;
  logic [CW-1:0]       cursor_q;
  logic [7:0]          cnt_q;
  logic                btn_q;
  logic                commit;
  logic                enc_one;

  assign commit  = btn && !btn_q && wr_en;
  assign enc_one = enc_add ^ enc_sub;

  assign rf_wdata = data_q;
  assign busy     = (state != IDLE);

  // Display mux: edit buffer in entry view, read data in browse view.
  always_comb begin
    disp_val = data_q[{disp_sel, 2'b00} +: 4];
    if (mode)
      disp_val = rf_rdata[{disp_sel, 2'b00} +: 4];
    disp_dot = !mode && (disp_sel == cursor_q);
  end

  // Edit buffer, cursor, address and commit handshake FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      data_q   <= '0;
      cursor_q <= '0;
      cnt_q    <= '0;
      btn_q    <= 1'b0;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      err      <= 1'b0;
    end else begin
      btn_q <= btn;
      unique case (state)
        IDLE: begin
          if (commit) begin
            err   <= 1'b0;
            rf_we <= 1'b1;
            cnt_q <= '0;
            state <= WRITE;
          end else begin
            if (clear) begin
              data_q   <= '0;
              cursor_q <= '0;
            end else if (!mode && !cur_sel && key_valid) begin
              data_q[{cursor_q, 2'b00} +: 4] <= key;
              cursor_q <= cursor_q + 1'b1;
            end
            if (enc_one) begin
              if (mode)
                rf_addr <= enc_add ? rf_addr + 1'b1
                                   : rf_addr - 1'b1;
              else if (cur_sel && !clear)
                cursor_q <= enc_add ? cursor_q + 1'b1
                                    : cursor_q - 1'b1;
            end
          end
        end
        WRITE: begin
          if (rf_ack) begin
            rf_we <= 1'b0;
`ifdef CMD_PROG_VERIFY_EN
            state <= VERIFY;
`else
            state <= ADV;
`endif
          end else if (cnt_q == TO_LAST) begin
            rf_we <= 1'b0;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        VERIFY: begin
`ifdef CMD_PROG_VERIFY_EN
          if (rf_rdata != data_q)
            err <= 1'b1;
          state <= ADV;
`else
          state <= IDLE;
`endif
        end
        ADV: begin
          rf_addr <= rf_addr + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_programmer.sv
// Directed bench for cmd_programmer (DIGITS=8, ADDR_W=3, ACK_TIMEOUT=15).
module tb_cmd_programmer;

`ifdef CMD_PROG_VERIFY_EN
  localparam int ADV_LAT = 3;
  localparam bit VER     = 1'b1;
`else
  localparam int ADV_LAT = 2;
  localparam bit VER     = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mode, cur_sel, wr_en, key_valid;
  logic [3:0]  key;
  logic        enc_add, enc_sub, btn, clear;
  logic [2:0]  disp_sel;
  logic [31:0] rf_rdata;
  logic        rf_ack;
  logic        rf_we;
  logic [2:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        busy, err;
  logic [3:0]  disp_val;
  logic        disp_dot;

  int tests_run = 0;
  int fails     = 0;

  cmd_programmer #(
    .DIGITS(8),
    .ADDR_W(3),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .cur_sel(cur_sel),
    .wr_en(wr_en),
    .key_valid(key_valid),
    .key(key),
    .enc_add(enc_add),
    .enc_sub(enc_sub),
    .btn(btn),
    .clear(clear),
    .disp_sel(disp_sel),
    .rf_rdata(rf_rdata),
    .rf_ack(rf_ack),
    .rf_we(rf_we),
    .rf_addr(rf_addr),
    .rf_wdata(rf_wdata),
    .busy(busy),
    .err(err),
    .disp_val(disp_val),
    .disp_dot(disp_dot)
  );

  always #10 clk = ~clk;

  task automatic press_key(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key       = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic pulse_enc(input logic a, input logic s);
    @(negedge clk);
    enc_add = a;
    enc_sub = s;
    @(negedge clk);
    enc_add = 1'b0;
    enc_sub = 1'b0;
  endtask

  task automatic pulse_clear(input logic with_key);
    @(negedge clk);
    clear     = 1'b1;
    key_valid = with_key;
    key       = 4'h9;
    @(negedge clk);
    clear     = 1'b0;
    key_valid = 1'b0;
  endtask

  // Raise btn, optionally ack the first WRITE edge, observe n cycles.
  task automatic run_commit(input bit ack_first, input int n,
                            input bit poke_btn,
                            output int busy_n, output int we_n,
                            output int addr_cyc,
                            input logic [2:0] addr_new);
    busy_n   = 0;
    we_n     = 0;
    addr_cyc = -1;
    @(negedge clk);
    btn = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (rf_we) we_n++;
      if (addr_cyc < 0 && rf_addr == addr_new) addr_cyc = c;
      rf_ack = (ack_first && c == 0);
      if (poke_btn && c == 3) btn = 1'b0;
      if (poke_btn && c == 4) btn = 1'b1;
    end
    btn    = 1'b0;
    rf_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    disp_sel = 3'd0;
    #1;
    tests_run++;
    if (rf_we !== 1'b0 || rf_addr !== 3'd0 || busy !== 1'b0 ||
        err !== 1'b0 || rf_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset: we=%b addr=%0d busy=%b err=%b wd=%h want 0s",
               rf_we, rf_addr, busy, err, rf_wdata);
    end
    tests_run++;
    if (disp_dot !== 1'b1) begin
      fails++;
      $display("FAIL reset_dot: got %b want 1", disp_dot);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_keys;
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    tests_run++;
    if (rf_wdata !== 32'h0000_0321) begin
      fails++;
      $display("FAIL keys_wdata: got %h want 00000321", rf_wdata);
    end
    for (int i = 0; i < 8; i++) begin
      disp_sel = 3'(i);
      #1;
      tests_run++;
      if (disp_dot !== (i == 3)) begin
        fails++;
        $display("FAIL keys_dot[%0d]: got %b want %b", i, disp_dot, i == 3);
      end
    end
    disp_sel = 3'd1;
    #1;
    tests_run++;
    if (disp_val !== 4'h2) begin
      fails++;
      $display("FAIL keys_disp: got %h want 2", disp_val);
    end
  endtask

  task automatic test_cursor;
    pulse_clear(1'b0);
    cur_sel = 1'b1;
    repeat (4) pulse_enc(1'b0, 1'b1);
    pulse_enc(1'b1, 1'b1);
    press_key(4'h7);
    for (int i = 0; i < 8; i++) begin
      disp_sel = 3'(i);
      #1;
      tests_run++;
      if (disp_dot !== (i == 4)) begin
        fails++;
        $display("FAIL cursor_dot[%0d]: got %b want %b", i, disp_dot, i == 4);
      end
    end
    tests_run++;
    if (rf_wdata !== 32'h0) begin
      fails++;
      $display("FAIL cursor_keyign: got %h want 00000000", rf_wdata);
    end
    cur_sel = 1'b0;
    press_key(4'h5);
    tests_run++;
    if (rf_wdata !== 32'h0005_0000) begin
      fails++;
      $display("FAIL cursor_key: got %h want 00050000", rf_wdata);
    end
    pulse_clear(1'b1);
    disp_sel = 3'd0;
    #1;
    tests_run++;
    if (rf_wdata !== 32'h0 || disp_dot !== 1'b1) begin
      fails++;
      $display("FAIL clear_prio: wd=%h dot=%b want 00000000 1",
               rf_wdata, disp_dot);
    end
  endtask

  task automatic test_addr;
    mode     = 1'b1;
    rf_rdata = 32'h1234_5678;
    repeat (7) pulse_enc(1'b1, 1'b0);
    tests_run++;
    if (rf_addr !== 3'd7) begin
      fails++;
      $display("FAIL addr_7: got %0d want 7", rf_addr);
    end
    pulse_enc(1'b1, 1'b0);
    tests_run++;
    if (rf_addr !== 3'd0) begin
      fails++;
      $display("FAIL addr_wrap: got %0d want 0", rf_addr);
    end
    pulse_enc(1'b1, 1'b1);
    tests_run++;
    if (rf_addr !== 3'd0) begin
      fails++;
      $display("FAIL addr_both: got %0d want 0", rf_addr);
    end
    pulse_enc(1'b0, 1'b1);
    tests_run++;
    if (rf_addr !== 3'd7) begin
      fails++;
      $display("FAIL addr_sub: got %0d want 7", rf_addr);
    end
    pulse_enc(1'b1, 1'b0);
    disp_sel = 3'd2;
    #1;
    tests_run++;
    if (disp_val !== 4'h6 || disp_dot !== 1'b0) begin
      fails++;
      $display("FAIL browse_disp: val=%h dot=%b want 6 0", disp_val, disp_dot);
    end
    mode = 1'b0;
  endtask

  task automatic test_commit;
    int b, w, a;
    pulse_clear(1'b0);
    press_key(4'hF); press_key(4'hE); press_key(4'hE); press_key(4'hB);
    press_key(4'hD); press_key(4'hA); press_key(4'hE); press_key(4'hD);
    tests_run++;
    if (rf_wdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL commit_buf: got %h want deadbeef", rf_wdata);
    end
    rf_rdata = 32'hDEAD_BEEF;
    run_commit(1'b1, 10, 1'b0, b, w, a, 3'd1);
    tests_run++;
    if (w !== 1 || b !== ADV_LAT || a !== ADV_LAT) begin
      fails++;
      $display("FAIL commit_timing: we=%0d busy=%0d addr_at=%0d want 1 %0d %0d",
               w, b, a, ADV_LAT, ADV_LAT);
    end
    tests_run++;
    if (rf_addr !== 3'd1 || err !== 1'b0 || rf_wdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL commit_end: addr=%0d err=%b wd=%h want 1 0 deadbeef",
               rf_addr, err, rf_wdata);
    end
  endtask

  task automatic test_timeout;
    int b, w, a;
    run_commit(1'b0, 25, 1'b1, b, w, a, 3'd2);
    tests_run++;
    if (w !== 15 || b !== 15) begin
      fails++;
      $display("FAIL timeout_len: we=%0d busy=%0d want 15 15", w, b);
    end
    tests_run++;
    if (err !== 1'b1 || rf_addr !== 3'd1 || a !== -1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_end: err=%b addr=%0d busy=%b want 1 1 0",
               err, rf_addr, busy);
    end
  endtask

  task automatic test_wr_en_off;
    int b, w, a;
    wr_en = 1'b0;
    run_commit(1'b1, 5, 1'b0, b, w, a, 3'd2);
    wr_en = 1'b1;
    tests_run++;
    if (b !== 0 || w !== 0 || err !== 1'b1) begin
      fails++;
      $display("FAIL wr_en_off: busy=%0d we=%0d err=%b want 0 0 1", b, w, err);
    end
  endtask

  task automatic test_verify_mismatch;
    int b, w, a;
    rf_rdata = 32'h0000_0000;
    run_commit(1'b1, 10, 1'b0, b, w, a, 3'd2);
    tests_run++;
    if (err !== VER || rf_addr !== 3'd2 || b !== ADV_LAT) begin
      fails++;
      $display("FAIL verify_mm: err=%b addr=%0d busy=%0d want %b 2 %0d",
               err, rf_addr, b, VER, ADV_LAT);
    end
  endtask

  task automatic test_reset_mid_write;
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (rf_we !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midw_pre: we=%b busy=%b want 1 1", rf_we, busy);
    end
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || rf_addr !== 3'd0 ||
        err !== 1'b0 || rf_wdata !== 32'h0) begin
      fails++;
      $display("FAIL midw_rst: we=%b busy=%b addr=%0d err=%b wd=%h want 0s",
               rf_we, busy, rf_addr, err, rf_wdata);
    end
    @(negedge clk);
    btn = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || rf_addr !== 3'd0) begin
      fails++;
      $display("FAIL midw_post: busy=%b addr=%0d want 0 0", busy, rf_addr);
    end
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    cur_sel   = 1'b0;
    wr_en     = 1'b1;
    key_valid = 1'b0;
    key       = 4'h0;
    enc_add   = 1'b0;
    enc_sub   = 1'b0;
    btn       = 1'b0;
    clear     = 1'b0;
    disp_sel  = 3'd0;
    rf_rdata  = 32'h0;
    rf_ack    = 1'b0;
    test_reset();
    test_keys();
    test_cursor();
    test_addr();
    test_commit();
    test_timeout();
    test_wr_en_off();
    test_verify_mismatch();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/cmd_programmer.md
# cmd_programmer

Parametrised command-entry and register-file programmer for the OLED controller front panel. It collects hexadecimal digits from the decoded keypad into an edit buffer with a cursor, and steers cursor and address from decoded encoder steps. A commit request writes the buffer to the register file through a request/acknowledge handshake with timeout, then auto-increments the address. It also multiplexes buffer or register-file nibbles to the seven-segment scanner.

## Interface

Parameters:
- DIGITS, 8: nibbles per command word; power of two, 2..16.
- ADDR_W, 3: register-file address width.
- ACK_TIMEOUT, 15: maximum cycles to wait for rf_ack; 1..255.

Ports (CW = log2(DIGITS)):
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mode  in  1  0: edit buffer view/entry; 1: register-file browse.
- cur_sel  in  1  1: encoder moves the cursor and keys are ignored (mode 0 only).
- wr_en  in  1  commit permitted when high.
- key_valid  in  1  one-cycle pulse with a decoded key.
- key  in  4  key value.
- enc_add, enc_sub  in  1 each  one-cycle encoder step pulses.
- btn  in  1  commit button, raw level; rising edge detected internally.
- clear  in  1  one-cycle pulse that zeroes the buffer and the cursor.
- disp_sel  in  CW  digit currently being scanned.
- rf_rdata  in  DIGITS*4  register-file read data at rf_addr.
- rf_ack  in  1  write acknowledge.
- rf_we  out  1  write request, active-high, registered.
- rf_addr  out  ADDR_W  register-file address, registered.
- rf_wdata  out  DIGITS*4  buffer contents; nibble i holds digit i.
- busy  out  1  high when the state is not IDLE.
- err  out  1  sticky: timeout, or verify mismatch.
- disp_val  out  4  nibble for disp_sel.
- disp_dot  out  1  active-high cursor dot.

## Operation

- Reset values: buffer 0, cursor 0, rf_addr 0, rf_we 0, err 0, btn history 0, state IDLE.
- Edits are accepted only in IDLE. While busy, key, clear and encoder inputs are ignored.
- mode=0, cur_sel=0, key_valid: buf[cursor] <= key, cursor <= cursor+1 modulo DIGITS.
- mode=0, cur_sel=1: enc_add increments the cursor and enc_sub decrements it, both modulo DIGITS.
- mode=1: enc_add increments rf_addr and enc_sub decrements it, both modulo 2^ADDR_W.
- If enc_add and enc_sub arrive together, neither takes effect.
- clear has priority over key_valid in the same cycle.
- Commit: btn rising edge (btn=1 and the previous sample was 0) in IDLE with wr_en=1 causes the following:
  - err <= 0.
  - rf_we <= 1.
  - state moves to WRITE.
  - A commit edge with wr_en=0, or one that arrives while busy, is dropped.
- WRITE:
  - rf_ack=1: rf_we <= 0, and state moves to VERIFY if verify is compiled in, otherwise to ADV.
  - No ack: the timeout counter increments. When it reaches ACK_TIMEOUT, rf_we <= 0, err <= 1, state returns to IDLE, and rf_addr is unchanged.
- VERIFY: if rf_rdata differs from the buffer, err <= 1. State moves to ADV either way.
- ADV: rf_addr <= rf_addr+1 (wraps), and state returns to IDLE.
- Display:
  - disp_val = mode ? rf_rdata nibble[disp_sel] : buf[disp_sel].
  - disp_dot = !mode and disp_sel == cursor.
  - Both are combinational.

## Timing

- The commit edge is sampled at edge N; rf_we is high from N+1.
- If rf_ack is sampled high at the first WRITE edge, rf_we is high for exactly 1 cycle.
- The rf_addr increment is visible 2 cycles after the ack edge with verify compiled in, and 1 cycle after it without.
- On timeout, rf_we is high for exactly ACK_TIMEOUT cycles.
- rf_wdata is stable for the whole time busy is high.
- Asserting rst mid-WRITE drops rf_we asynchronously and returns the block to its reset values. No partial increment occurs.

## Configuration

- CMD_PROG_VERIFY_EN:
  - Defined: the VERIFY state is present and read-back mismatches set err.
  - Undefined: WRITE goes directly to ADV, err is set only by timeout, and the commit-to-increment latency is 1 cycle shorter.

## Test plan

- Reset, then keys 1,2,3 → rf_wdata[11:0]=0x321, cursor=3, disp_dot high only when disp_sel=3.
- cur_sel=1, 4 enc_sub pulses from cursor 0 with DIGITS=8 → cursor=4. Next, clear together with key_valid → buffer 0, cursor 0.
- mode=1, rf_addr=7 (ADDR_W=3), enc_add → rf_addr=0. Simultaneous add+sub → unchanged.
- Buffer 0xDEADBEEF, btn edge, rf_ack on the first WRITE cycle, rf_rdata matches → rf_we pulses 1 cycle, err=0, rf_addr 0→1, busy for 3 cycles with verify compiled in.
- Commit with no ack and ACK_TIMEOUT=15 → rf_we high 15 cycles, err=1, rf_addr unchanged. A second commit edge during busy is ignored.
- Verify compiled in, rf_rdata differs from the buffer after ack → err=1 and the address still increments. rst asserted during a WRITE → rf_we=0 immediately and all outputs return to their reset values.
